alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- RV32I integer execute block: a combinational control decoder maps {opcode, func_code} to an internal 7-bit ALU control word, and the ALU computes result and branch condition from operands a/b.
- Result and branch flag are registered once, so latency is one cycle.
- Sits in the processor execute stage, between register-file/immediate muxing and writeback/PC-select.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported; shift amount is always b[4:0].

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- a  in  32  operand A (rs1 or PC).
- b  in  32  operand B (rs2 or immediate).
- func_code  in  4  {instr[30], funct3}.
- opcode  in  7  instr[6:0].
- alu_out  out  32  registered result.
- branch_enable  out  1  registered branch-taken flag.

Behaviour:
- Clocking and reset:
  - One clock domain; reset is synchronous and active-high.
  - While reset is high at a rising edge: alu_out <= 0, branch_enable <= 0.
  - Reset has priority over new inputs; the first valid result appears on the edge after reset deasserts.
- Latency and handshake:
  - Inputs are sampled at edge N; outputs are valid after edge N and held until edge N+1.
  - Fully pipelined, one op per cycle, no handshake.
- Control word alu_ctl[6:0]:
  - [3:0] op: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 SLTU, 6 SRL, 7 SRA, 8 SLL, 9 XOR, 10 PASS_B, 15 ZERO.
  - [6:4] branch condition: 0 none, 1 EQ, 2 NE, 3 LT, 4 GE, 5 LTU, 6 GEU.
- Decode by opcode:
  - 0110011 (R-type): funct3 000 gives ADD, or SUB when func_code[3]=1. Then 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, or SRA when func_code[3]=1, 110 OR, 111 AND.
  - 0010011 (I-type): same mapping, except func_code[3] is ignored for 000, so ADDI is always ADD. func_code[3] selects SRA only for 101.
  - 0110111 (LUI): PASS_B.
  - 0010111 (AUIPC), 0000011 (load), 0100011 (store), 1101111 (JAL), 1100111 (JALR): ADD.
  - 1100011 (branch): op SUB; condition from funct3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. Funct3 010/011 give condition none.
  - Any other opcode: ZERO op, condition none.
- Arithmetic:
  - All results modulo 2^32.
  - SLT uses a signed compare and SLTU an unsigned compare; the result is 1 or 0, zero-extended.
  - Shifts use b[4:0]; SRA replicates a[31].
- branch_enable: evaluates the condition on a vs b (signed for LT/GE, unsigned for LTU/GEU). It is 0 when the condition is none.
- Boundary cases:
  - Shift by 0 returns a.
  - 0x80000000 - 1 wraps to 0x7FFFFFFF.
  - SLT of 0x80000000 < 0 is 1; SLTU of the same is 0.

Optional Feature:
- Macro ALU_CTL_OBS_EN.
- Defined: adds output port alu_ctl_q [6:0], the registered control word (reset value 7'h0F, ZERO/none), aligned with alu_out.
- Undefined: port and register are absent; functionality is otherwise identical.

Decomposition:
- Package alu_exec_pkg: opcode constants, funct3 constants, the 4-bit op enum, the 3-bit branch-condition enum, and a typedef for the 7-bit control word.
- One natural sub-module: alu_ctl_decode (combinational, opcode/func_code to control word). The ALU datapath and output registers stay in the top module.

Test Plan:
- Reset held 2 cycles with nonzero inputs -> alu_out=0, branch_enable=0; first result appears one cycle after release.
- R-type AND a=0x0F b=0x55 fc=0111 -> 0x05; OR fc=0110 -> 0x5F; XOR a=0x55 b=0xFF fc=0100 -> 0xAA.
- R-type ADD a=10000 b=111 fc=0000 -> 10111; SUB fc=1000 -> 9889; SUB a=0x80000000 b=1 -> 0x7FFFFFFF.
- Shifts: SRL a=16 b=2 -> 4; SRA a=8 b=1 -> 4; SRA a=0x80000000 b=4 -> 0xF8000000; SLL a=2 b=2 -> 8; SLL b=32 -> a unchanged.
- Compares: SLT a=0 b=2 -> 1; SLT a=0x80000000 b=0 -> 1; SLTU same -> 0. Branch BEQ a=b=5 -> branch_enable=1; BLTU a=0xFFFFFFFF b=1 -> 0; BGE a=-1 b=-1 -> 1.
- Opcode 0110111 b=0x12345000 -> 0x12345000; illegal opcode 0000000 -> alu_out=0, branch_enable=0. Back-to-back ops each cycle -> each result appears exactly one cycle later.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared types for the RV32I execute block: opcode/funct3 constants,
// ALU op and branch-condition encodings, and the 7-bit control word.
package alu_exec_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
    OP_SLT = 4'd4, OP_SLTU = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
    OP_SLL = 4'd8, OP_XOR = 4'd9, OP_PASS_B = 4'd10, OP_ZERO = 4'd15
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0, BR_EQ = 3'd1, BR_NE = 3'd2, BR_LT = 3'd3,
    BR_GE = 3'd4, BR_LTU = 3'd5, BR_GEU = 3'd6
  } br_cond_e;

  // cond occupies bits [6:4], op bits [3:0]
  typedef struct packed {
    br_cond_e cond;
    alu_op_e  op;
  } alu_ctl_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational decode of {opcode, func_code} into the ALU control word.
module alu_ctl_decode
  import alu_exec_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [3:0] func_code,
  output alu_ctl_t   ctl
);

  logic [2:0] funct3;
  logic       alt;

  assign funct3 = func_code[2:0];
  assign alt    = func_code[3];

  always_comb begin
    ctl.cond = BR_NONE;
    ctl.op   = OP_ZERO;
    case (opcode)
      OPC_RTYPE, OPC_ITYPE: begin
        case (funct3)
          // ADDI has no SUB form; bit 30 is immediate data there
          F3_ADD:  ctl.op = (alt && opcode == OPC_RTYPE) ? OP_SUB : OP_ADD;
          F3_SLL:  ctl.op = OP_SLL;
          F3_SLT:  ctl.op = OP_SLT;
          F3_SLTU: ctl.op = OP_SLTU;
          F3_XOR:  ctl.op = OP_XOR;
          F3_SR:   ctl.op = alt ? OP_SRA : OP_SRL;
          F3_OR:   ctl.op = OP_OR;
          default: ctl.op = OP_AND;
        endcase
      end
      OPC_LUI: ctl.op = OP_PASS_B;
      OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR: ctl.op = OP_ADD;
      OPC_BRANCH: begin
        ctl.op = OP_SUB;
        case (funct3)
          F3_BEQ:  ctl.cond = BR_EQ;
          F3_BNE:  ctl.cond = BR_NE;
          F3_BLT:  ctl.cond = BR_LT;
          F3_BGE:  ctl.cond = BR_GE;
          F3_BLTU: ctl.cond = BR_LTU;
          F3_BGEU: ctl.cond = BR_GEU;
          default: ctl.cond = BR_NONE;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// RV32I execute unit: decode, ALU and branch compare, one-cycle registered output.
// Optional ALU_CTL_OBS_EN exposes the registered control word as alu_ctl_q.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       func_code,
  input  logic [6:0]       opcode,
`ifdef ALU_CTL_OBS_EN
  output logic [6:0]       alu_ctl_q,
`endif
  output logic [WIDTH-1:0] alu_out,
  output logic             branch_enable
);

  alu_ctl_t         ctl;
  logic [WIDTH-1:0] res_d;
  logic             br_d;
  logic             eq, lt, ltu;
  logic [4:0]       shamt;

  alu_ctl_decode u_dec (
    .opcode    (opcode),
    .func_code (func_code),
    .ctl       (ctl)
  );

  assign shamt = b[4:0];
  assign eq    = (a == b);
  assign lt    = ($signed(a) < $signed(b));
  assign ltu   = (a < b);

  always_comb begin
    res_d = '0;
    case (ctl.op)
      OP_AND:    res_d = a & b;
      OP_OR:     res_d = a | b;
      OP_ADD:    res_d = a + b;
      OP_SUB:    res_d = a - b;
      OP_SLT:    res_d = {{(WIDTH-1){1'b0}}, lt};
      OP_SLTU:   res_d = {{(WIDTH-1){1'b0}}, ltu};
      OP_SRL:    res_d = a >> shamt;
      OP_SRA:    res_d = $signed(a) >>> shamt;
      OP_SLL:    res_d = a << shamt;
      OP_XOR:    res_d = a ^ b;
      OP_PASS_B: res_d = b;
      default:   res_d = '0;
    endcase
  end

  always_comb begin
    br_d = 1'b0;
    case (ctl.cond)
      BR_EQ:   br_d = eq;
      BR_NE:   br_d = !eq;
      BR_LT:   br_d = lt;
      BR_GE:   br_d = !lt;
      BR_LTU:  br_d = ltu;
      BR_GEU:  br_d = !ltu;
      default: br_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_out       <= '0;
      branch_enable <= 1'b0;
    end else begin
      alu_out       <= res_d;
      branch_enable <= br_d;
    end
  end

`ifdef ALU_CTL_OBS_EN
  always_ff @(posedge clk) begin
    if (reset) alu_ctl_q <= 7'h0F;
    else       alu_ctl_q <= ctl;
  end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [3:0]  func_code;
  logic [6:0]  opcode;
  logic [31:0] alu_out;
  logic        branch_enable;
`ifdef ALU_CTL_OBS_EN
  logic [6:0]  alu_ctl_q;
`endif

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .a             (a),
    .b             (b),
    .func_code     (func_code),
    .opcode        (opcode),
`ifdef ALU_CTL_OBS_EN
    .alu_ctl_q     (alu_ctl_q),
`endif
    .alu_out       (alu_out),
    .branch_enable (branch_enable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [3:0] fc, input logic [6:0] opc);
    a = ia; b = ib; func_code = fc; opcode = opc;
  endtask

  // One op per cycle: drive, clock once, check the registered result.
  task automatic run(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                     input logic [3:0] fc, input logic [6:0] opc,
                     input logic [31:0] eo, input logic eb);
    drive(ia, ib, fc, opc);
    @(posedge clk); #1;
    chk({tag, ".out"}, alu_out, eo);
    chk({tag, ".br"}, {31'd0, branch_enable}, {31'd0, eb});
  endtask

  initial begin
    reset = 1'b1;
    drive(32'd5, 32'd3, 4'b0000, R);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out", alu_out, 32'd0);
    chk("rst.br", {31'd0, branch_enable}, 32'd0);
`ifdef ALU_CTL_OBS_EN
    chk("rst.ctl", {25'd0, alu_ctl_q}, 32'h0F);
`endif
    reset = 1'b0;
    @(posedge clk); #1;
    chk("first.out", alu_out, 32'd8);

    run("and",  32'h0F, 32'h55, 4'b0111, R, 32'h05, 1'b0);
    run("or",   32'h0F, 32'h55, 4'b0110, R, 32'h5F, 1'b0);
    run("xor",  32'h55, 32'hFF, 4'b0100, R, 32'hAA, 1'b0);
    run("add",  32'd10000, 32'd111, 4'b0000, R, 32'd10111, 1'b0);
    run("sub",  32'd10000, 32'd111, 4'b1000, R, 32'd9889, 1'b0);
    run("subw", 32'h80000000, 32'd1, 4'b1000, R, 32'h7FFFFFFF, 1'b0);
    run("addi", 32'd10, 32'd3, 4'b1000, I, 32'd13, 1'b0);

    run("srl",   32'd16, 32'd2, 4'b0101, R, 32'd4, 1'b0);
    run("sra",   32'd8, 32'd1, 4'b1101, R, 32'd4, 1'b0);
    run("sran",  32'h80000000, 32'd4, 4'b1101, R, 32'hF8000000, 1'b0);
    run("srai",  32'h80000000, 32'd4, 4'b1101, I, 32'hF8000000, 1'b0);
    run("srli",  32'h80000000, 32'd4, 4'b0101, I, 32'h08000000, 1'b0);
    run("sll",   32'd2, 32'd2, 4'b0001, R, 32'd8, 1'b0);
    run("sll32", 32'd2, 32'd32, 4'b0001, R, 32'd2, 1'b0);

    run("slt",   32'd0, 32'd2, 4'b0010, R, 32'd1, 1'b0);
    run("sltn",  32'h80000000, 32'd0, 4'b0010, R, 32'd1, 1'b0);
    run("sltu",  32'h80000000, 32'd0, 4'b0011, R, 32'd0, 1'b0);

    run("beq",   32'd5, 32'd5, 4'b0000, BR, 32'd0, 1'b1);
    run("bne",   32'd5, 32'd5, 4'b0001, BR, 32'd0, 1'b0);
    run("bltu",  32'hFFFFFFFF, 32'd1, 4'b0110, BR, 32'hFFFFFFFE, 1'b0);
    run("blt",   32'hFFFFFFFF, 32'd1, 4'b0100, BR, 32'hFFFFFFFE, 1'b1);
    run("bge",   32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0101, BR, 32'd0, 1'b1);
    run("bgeu",  32'd1, 32'hFFFFFFFF, 4'b0111, BR, 32'd2, 1'b0);
    run("bnone", 32'd5, 32'd5, 4'b0010, BR, 32'd0, 1'b0);

    run("lui",   32'd7, 32'h12345000, 4'b0000, LUI, 32'h12345000, 1'b0);
    run("jal",   32'h1000, 32'd4, 4'b0000, JAL, 32'h1004, 1'b0);
    run("beq1",  32'd9, 32'd9, 4'b0000, BR, 32'd0, 1'b1);
    run("bad",   32'd9, 32'd9, 4'b0000, BAD, 32'd0, 1'b0);

    // Back-to-back: output must hold until the next edge, then update.
    drive(32'd1, 32'd2, 4'b0000, R);
    @(posedge clk); #1;
    chk("b2b0.out", alu_out, 32'd3);
    drive(32'd7, 32'd2, 4'b1000, R);
    @(negedge clk);
    chk("b2b.hold", alu_out, 32'd3);
    @(posedge clk); #1;
    chk("b2b1.out", alu_out, 32'd5);
    drive(32'hF0, 32'h3C, 4'b0111, R);
    @(posedge clk); #1;
    chk("b2b2.out", alu_out, 32'h30);

    // Reset mid-stream takes priority over live inputs.
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst2.out", alu_out, 32'd0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
